lut_layer_sched: RTL and testbench
==================================

LUT_LAYER_SCHED -- requirements
Module: lut_layer_sched

Interface
REQ-001 Parameter NUM_NEURONS, default 8: number of LUT neurons evaluated per layer pass.
REQ-002 Parameter FANIN_BITS, default 8: per-neuron truth-table address width, giving 2^FANIN_BITS entries.
REQ-003 Parameter OUT_BITS, default 1: per-neuron output width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  input vector available.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  NUM_NEURONS*FANIN_BITS  pre-gathered fan-in; neuron k uses slice [k*FANIN_BITS +: FANIN_BITS].
REQ-009 out_valid  output  1  out_data holds a complete layer result.
REQ-010 out_ready  input  1  consumer takes out_data.
REQ-011 out_data  output  NUM_NEURONS*OUT_BITS  neuron k result in slice [k*OUT_BITS +: OUT_BITS].
REQ-012 cfg_we  input  1  truth-table write strobe.
REQ-013 cfg_addr  input  clog2(NUM_NEURONS)+FANIN_BITS  {neuron index, table entry}.
REQ-014 cfg_data  input  OUT_BITS  entry value.
REQ-015 cfg_ready  output  1  high only in IDLE; cfg_we is ignored while cfg_ready is low.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, EVAL, DRAIN and HOLD.
REQ-018 IDLE: in_ready=1 and cfg_ready=1; on in_valid&&in_ready, in_data is captured into an internal register, idx is cleared to 0, and the state moves to EVAL.
REQ-019 EVAL: each cycle, issue a synchronous table read at {idx, captured slice idx}, then increment idx; after issuing idx=NUM_NEURONS-1, move to DRAIN.
REQ-020 Table read latency is exactly 1 cycle; the returned entry is written to out_data slice idx-1 (delayed index) on the following edge.
REQ-021 DRAIN: write the last returned entry, assert out_valid, and move to HOLD.
REQ-022 out_valid SHALL first be high NUM_NEURONS+1 rising edges after the accepting edge (9 for defaults).
REQ-023 HOLD: out_valid=1, and out_data is stable; on out_ready, return to IDLE.
REQ-024 If in_valid arrives while in HOLD with out_ready, it is not accepted; in_ready stays 0 outside IDLE, with no back-to-back bypass.
REQ-025 out_data SHALL keep its last value after HOLD until the next DRAIN completes; bits are not cleared per pass.
REQ-026 A cfg_we in IDLE coinciding with an accepted in_valid SHALL be applied first; the ensuing EVAL reads the new value.
REQ-027 idx SHALL be clog2(NUM_NEURONS) bits wide and SHALL not wrap past NUM_NEURONS-1 (EVAL exit precedes wrap); NUM_NEURONS=1 goes EVAL->DRAIN after one cycle.
REQ-028 Table contents are undefined after power-up and are unaffected by rst_n.

Reset
REQ-029 While rst_n=0: state=IDLE, idx=0, out_valid=0, out_data=0, busy=0, in_ready=1, cfg_ready=1.
REQ-030 Reset asserted mid-EVAL or mid-HOLD SHALL abort the pass immediately; no partial result is ever flagged valid.
REQ-031 Deassertion of rst_n SHALL be synchronised internally, using a 2-flop release, before the FSM leaves IDLE.

Structure
REQ-032 The package lutnet_pkg SHALL hold the FSM state enum, the default parameter constants, and a function computing cfg_addr width.
REQ-033 The storage SHALL be one sub-module, lut_table_ram: NUM_NEURONS*2^FANIN_BITS x OUT_BITS, 1 write port, 1 synchronous read port, distributed RAM style.
REQ-034 The controller SHALL contain no per-neuron combinational ROMs; all neuron functions come from lut_table_ram.

Verification
REQ-035 Load: table neuron k has entry 8'hA5=1 for even k, else 0; in_data all bytes 8'hA5 -> out_data=8'b01010101, out_valid exactly 9 edges after acceptance.
REQ-036 Hold out_ready=0 for 20 cycles in HOLD -> out_data/out_valid stable, in_ready=0 throughout, a concurrent cfg_we does not alter the table.
REQ-037 Pulse rst_n low during EVAL cycle 4 -> out_valid stays 0, state IDLE, out_data=0; the next pass yields the correct 8'b01010101.
REQ-038 Same-cycle cfg_we(neuron 1, 8'hA5, 1) with accepted input -> out_data=8'b01010111.
REQ-039 Two back-to-back inputs with out_ready tied high -> second accepted exactly 1 cycle after first HOLD, each result correct, no lost or duplicated out_valid.
REQ-040 NUM_NEURONS=1 build: single entry table=1 at input 8'h00 -> out_data=1, out_valid 2 edges after acceptance.

Source files
------------

// File: rtl/lutnet_pkg.sv
// Shared definitions for the LUT layer scheduler.
//   state_t         : controller FSM states
//   DEF_*           : default build parameters
//   idx_width()     : neuron index width (at least 1 bit so a 1-neuron build still has a register)
//   cfg_addr_width(): width of the {neuron index, table entry} configuration address
package lutnet_pkg;

    localparam int DEF_NUM_NEURONS = 8;
    localparam int DEF_FANIN_BITS  = 8;
    localparam int DEF_OUT_BITS    = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic int idx_width(input int num_neurons);
        return (num_neurons > 1) ? $clog2(num_neurons) : 1;
    endfunction

    function automatic int cfg_addr_width(input int num_neurons, input int fanin_bits);
        return idx_width(num_neurons) + fanin_bits;
    endfunction

endpackage

// File: rtl/lut_layer_sched_if.sv
// Bundle of the scheduler's data and configuration handshakes.
//   in_valid/in_ready/in_data    : layer input vector, one FANIN_BITS slice per neuron
//   out_valid/out_ready/out_data : layer result, one OUT_BITS slice per neuron
//   cfg_we/cfg_addr/cfg_data     : truth-table write port, honoured only while cfg_ready
//   cfg_ready/busy               : controller status
// master = producer/consumer side, slave = scheduler side.
interface lut_layer_sched_if
    import lutnet_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int FANIN_BITS  = DEF_FANIN_BITS,
    parameter int OUT_BITS    = DEF_OUT_BITS
);
    localparam int ADDR_W = cfg_addr_width(NUM_NEURONS, FANIN_BITS);

    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_NEURONS*FANIN_BITS-1:0] in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_NEURONS*OUT_BITS-1:0] out_data;
    logic                            cfg_we;
    logic [ADDR_W-1:0]               cfg_addr;
    logic [OUT_BITS-1:0]             cfg_data;
    logic                            cfg_ready;
    logic                            busy;

    modport master (
        output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_data, cfg_ready, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, out_data, cfg_ready, busy
    );
endinterface

// File: rtl/lut_table_ram.sv
// Truth-table storage for every neuron of the layer: DEPTH x DATA_W,
// one write port, one synchronous read port (1-cycle latency). Small and
// read-every-cycle, so it is meant to map onto distributed (LUT) RAM.
//   clk   : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata valid the cycle after re
module lut_table_ram #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    // With a single neuron the index field is a constant 0, so the storage
    // needs fewer address bits than the configuration address carries.
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; its contents are configuration that must
    // survive rst_n, and a reset would also stop it mapping onto RAM cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[MEM_AW-1:0]] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr[MEM_AW-1:0]];
        end
    end
endmodule

// File: rtl/lut_layer_sched.sv
// Evaluates one layer of LUT neurons per accepted input vector, one neuron per
// cycle, by reading each neuron's truth table from a shared lut_table_ram.
//   clk, rst_n : clock, asynchronous active-low reset (release synchronised)
//   bus        : lut_layer_sched_if.slave (input, output and config handshakes)
// Accepting edge -> NUM_NEURONS EVAL edges -> DRAIN edge raises out_valid,
// i.e. out_valid is first seen NUM_NEURONS+1 edges after acceptance.
module lut_layer_sched
    import lutnet_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int FANIN_BITS  = DEF_FANIN_BITS,
    parameter int OUT_BITS    = DEF_OUT_BITS
) (
    input logic              clk,
    input logic              rst_n,
    lut_layer_sched_if.slave bus
);
    localparam int IDX_W  = idx_width(NUM_NEURONS);
    localparam int ADDR_W = cfg_addr_width(NUM_NEURONS, FANIN_BITS);
    localparam int DEPTH  = NUM_NEURONS * (2 ** FANIN_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    // Reset asserts immediately but releases only after two clock edges, so
    // the FSM never leaves reset on a metastable edge.
    logic [1:0] rst_sync;
    logic       srst_n;

    // NOTE: every sequential block uses non-blocking assignments so that all
    // registers sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign srst_n = rst_sync[1];

    state_t                            state;
    logic [IDX_W-1:0]                  idx;
    logic [IDX_W-1:0]                  idx_d;    // neuron whose entry is returning
    logic                              rd_pend;  // a table read was issued last cycle
    logic [NUM_NEURONS*FANIN_BITS-1:0] cap_q;
    logic [NUM_NEURONS*OUT_BITS-1:0]   out_data_q;
    logic                              out_valid_q;
    logic                              in_ready_q;
    logic                              cfg_ready_q;
    logic                              busy_q;

    logic                              rd_en;
    logic [ADDR_W-1:0]                 rd_addr;
    logic [OUT_BITS-1:0]               rd_data;

    assign rd_en   = (state == EVAL);
    assign rd_addr = {idx, cap_q[int'(idx)*FANIN_BITS +: FANIN_BITS]};

    // Writes are gated by cfg_ready so the table cannot change under a pass.
    // A write on the accepting edge lands before the first EVAL read.
    lut_table_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DATA_W (OUT_BITS)
    ) u_table (
        .clk   (clk),
        .we    (bus.cfg_we & cfg_ready_q),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state       <= IDLE;
            idx         <= '0;
            idx_d       <= '0;
            rd_pend     <= 1'b0;
            cap_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            rd_pend <= 1'b0;
            // Entry read one cycle ago lands in its neuron's slice; this covers
            // EVAL cycles 2..N and the final entry in DRAIN.
            if (rd_pend) begin
                out_data_q[int'(idx_d)*OUT_BITS +: OUT_BITS] <= rd_data;
            end

            unique case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        cap_q       <= bus.in_data;
                        idx         <= '0;
                        state       <= EVAL;
                        in_ready_q  <= 1'b0;
                        cfg_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                EVAL: begin
                    rd_pend <= 1'b1;
                    idx_d   <= idx;
                    // Leave before idx would wrap past the last neuron.
                    if (idx == LAST_IDX) begin
                        state <= DRAIN;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    out_valid_q <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        cfg_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.cfg_ready = cfg_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_lut_layer_sched.sv
// Self-checking bench: an 8-neuron build and a 1-neuron build of lut_layer_sched.
// The reference model is a plain array of truth tables indexed by neuron and
// fan-in byte; expected results and latencies come from that and from constants.
module tb_lut_layer_sched;
    localparam int N = 8;
    localparam int F = 8;
    localparam int O = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lut_layer_sched_if #(.NUM_NEURONS(N), .FANIN_BITS(F), .OUT_BITS(O)) bus0 ();
    lut_layer_sched_if #(.NUM_NEURONS(1), .FANIN_BITS(F), .OUT_BITS(O)) bus1 ();

    lut_layer_sched #(.NUM_NEURONS(N), .FANIN_BITS(F), .OUT_BITS(O)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    lut_layer_sched #(.NUM_NEURONS(1), .FANIN_BITS(F), .OUT_BITS(O)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    int vectors = 0;
    int miscompares = 0;
    bit ref_tbl [N][256];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [N*F-1:0] d);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = ref_tbl[k][d[k*F +: F]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready(input string tag);
        int n = 0;
        while (!bus0.in_ready && n < 100) begin
            tick();
            n++;
        end
        chk({tag, " in_ready"}, bus0.in_ready, 1);
    endtask

    // One full pass on the 8-neuron build, released with a single out_ready pulse.
    task automatic run_pass(input string tag, input logic [N*F-1:0] d);
        int n;
        wait_in_ready(tag);
        bus0.in_valid = 1'b1;
        bus0.in_data  = d;
        tick();
        bus0.in_valid = 1'b0;
        n = 0;
        while (!bus0.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, n, 9);
        chk({tag, " data"}, bus0.out_data, model(d));
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
        chk({tag, " released"}, bus0.out_valid, 0);
        chk({tag, " data kept"}, bus0.out_data, model(d));
    endtask

    initial begin
        logic [N*F-1:0] a5_vec;
        logic [N*F-1:0] d1;
        logic [N*F-1:0] d2;
        logic [N-1:0]   held;
        int n;

        a5_vec = {N{8'hA5}};
        bus0.in_valid = 0; bus0.in_data = '0; bus0.out_ready = 0;
        bus0.cfg_we = 0; bus0.cfg_addr = '0; bus0.cfg_data = '0;
        bus1.in_valid = 0; bus1.in_data = '0; bus1.out_ready = 0;
        bus1.cfg_we = 0; bus1.cfg_addr = '0; bus1.cfg_data = '0;

        for (int k = 0; k < N; k++) begin
            for (int e = 0; e < 256; e++) ref_tbl[k][e] = 1'($urandom_range(0, 1));
            ref_tbl[k][8'hA5] = (k % 2 == 0);
        end

        // Reset state
        repeat (2) tick();
        chk("rst in_ready", bus0.in_ready, 1);
        chk("rst cfg_ready", bus0.cfg_ready, 1);
        chk("rst busy", bus0.busy, 0);
        chk("rst out_valid", bus0.out_valid, 0);
        chk("rst out_data", bus0.out_data, 0);
        chk("rst1 out_valid", bus1.out_valid, 0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Load the whole table (contents are undefined after power-up)
        for (int k = 0; k < N; k++) begin
            for (int e = 0; e < 256; e++) begin
                bus0.cfg_we   = 1'b1;
                bus0.cfg_addr = {3'(k), 8'(e)};
                bus0.cfg_data = ref_tbl[k][e];
                tick();
            end
        end
        bus0.cfg_we = 1'b0;

        run_pass("a5", a5_vec);
        chk("a5 literal", bus0.out_data, 8'b01010101);

        // Stall in HOLD for 20 cycles with a config write and a new input offered
        wait_in_ready("hold");
        bus0.in_valid = 1'b1;
        bus0.in_data  = a5_vec;
        tick();
        bus0.in_valid = 1'b0;
        repeat (9) tick();
        chk("hold entry valid", bus0.out_valid, 1);
        held = bus0.out_data;
        chk("hold entry data", held, 8'b01010101);
        for (int c = 0; c < 20; c++) begin
            bus0.cfg_we   = (c == 5);
            bus0.cfg_addr = {3'd0, 8'hA5};
            bus0.cfg_data = 1'b0;
            bus0.in_valid = 1'b1;
            bus0.in_data  = '0;
            tick();
            chk("hold valid", bus0.out_valid, 1);
            chk("hold data", bus0.out_data, held);
            chk("hold in_ready", bus0.in_ready, 0);
        end
        bus0.cfg_we = 1'b0;
        // in_valid still high as out_ready releases HOLD: must not be taken
        bus0.out_ready = 1'b1;
        tick();
        chk("no bypass busy", bus0.busy, 0);
        chk("no bypass in_ready", bus0.in_ready, 1);
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b0;
        run_pass("after hold", a5_vec);

        // Random fan-in patterns
        for (int t = 0; t < 12; t++) begin
            d1 = {$urandom, $urandom};
            if (t % 3 == 0) d1[15:8] = 8'hA5;
            run_pass("random", d1);
        end

        // Reset pulse during EVAL cycle 4
        wait_in_ready("rst mid");
        bus0.in_valid = 1'b1;
        bus0.in_data  = a5_vec;
        tick();
        bus0.in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("mid rst out_valid", bus0.out_valid, 0);
        chk("mid rst busy", bus0.busy, 0);
        chk("mid rst in_ready", bus0.in_ready, 1);
        chk("mid rst out_data", bus0.out_data, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("post rst out_valid", bus0.out_valid, 0);
        end
        chk("post rst busy", bus0.busy, 0);
        run_pass("post rst", a5_vec);
        chk("post rst literal", bus0.out_data, 8'b01010101);

        // Config write on the accepting edge is seen by the same pass
        wait_in_ready("same cycle");
        ref_tbl[1][8'hA5] = 1'b1;
        bus0.cfg_we   = 1'b1;
        bus0.cfg_addr = {3'd1, 8'hA5};
        bus0.cfg_data = 1'b1;
        bus0.in_valid = 1'b1;
        bus0.in_data  = a5_vec;
        tick();
        bus0.cfg_we   = 1'b0;
        bus0.in_valid = 1'b0;
        n = 0;
        while (!bus0.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("same cycle latency", n, 9);
        chk("same cycle literal", bus0.out_data, 8'b01010111);
        chk("same cycle model", bus0.out_data, model(a5_vec));
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;

        // Back-to-back inputs with out_ready tied high
        begin
            int v1, v2, a2, nv;
            logic [N-1:0] o1, o2;
            logic acc_now;
            d1 = {$urandom, $urandom};
            d2 = {$urandom, $urandom};
            v1 = -1; v2 = -1; a2 = -1; nv = 0; o1 = '0; o2 = '0;
            wait_in_ready("b2b");
            bus0.out_ready = 1'b1;
            bus0.in_valid  = 1'b1;
            bus0.in_data   = d1;
            tick();
            bus0.in_data = d2;
            for (int c = 1; c <= 30; c++) begin
                acc_now = bus0.in_valid && bus0.in_ready;
                tick();
                if (acc_now) begin
                    a2 = c;
                    bus0.in_valid = 1'b0;
                end
                if (bus0.out_valid) begin
                    nv++;
                    if (nv == 1) begin v1 = c; o1 = bus0.out_data; end
                    else if (nv == 2) begin v2 = c; o2 = bus0.out_data; end
                end
            end
            bus0.out_ready = 1'b0;
            bus0.in_valid  = 1'b0;
            chk("b2b first valid edge", v1, 9);
            chk("b2b first data", o1, model(d1));
            chk("b2b second accept edge", a2, 11);
            chk("b2b second valid edge", v2, 20);
            chk("b2b second data", o2, model(d2));
            chk("b2b valid count", nv, 2);
        end

        // Single-neuron build
        bus1.cfg_we   = 1'b1;
        bus1.cfg_addr = 9'h000;
        bus1.cfg_data = 1'b1;
        tick();
        bus1.cfg_addr = 9'h001;
        bus1.cfg_data = 1'b0;
        tick();
        bus1.cfg_we = 1'b0;
        for (int t = 0; t < 2; t++) begin
            bus1.in_valid = 1'b1;
            bus1.in_data  = 8'(t);
            tick();
            bus1.in_valid = 1'b0;
            n = 0;
            while (!bus1.out_valid && n < 20) begin
                tick();
                n++;
            end
            chk("n1 latency", n, 2);
            chk("n1 data", bus1.out_data, (t == 0) ? 1 : 0);
            bus1.out_ready = 1'b1;
            tick();
            bus1.out_ready = 1'b0;
            chk("n1 released", bus1.out_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
